// File: rtl/tts_host_msg_tx_pkg.sv
// Shared host-message definitions: field offsets, byte counts, RAM-select encoding,
// the 256-bit host-message struct and the TX FSM state enum.
package tts_host_msg_tx_pkg;

    localparam int MSG_W       = 256;
    localparam int CMD_LSB     = 248;
    localparam int RAM_LSB     = 240;
    localparam int ADDR_LSB    = 224;
    localparam int RES_LSB     = 216;
    localparam int BYTE_EN_LSB = 192;
    localparam int DATA_LSB    = 0;
    localparam int DATA_BYTES  = 24;
    localparam int DATA_W      = DATA_BYTES * 8;
    localparam int BYTE_EN_W   = DATA_BYTES;

    typedef enum logic [7:0] {
        RAM_SRCB = 8'h01,
        RAM_PRCB = 8'h02,
        RAM_VRCB = 8'h04,
        RAM_ORCB = 8'h08
    } ram_sel_e;

    typedef struct packed {
        logic [7:0]           cmd;
        logic [7:0]           ram;
        logic [15:0]          addr;
        logic [7:0]           res;
        logic [BYTE_EN_W-1:0] byte_en;
        logic [DATA_W-1:0]    data;
    } host_msg_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    function automatic logic is_good_ram(input logic [7:0] ram);
        case (ram)
            RAM_SRCB, RAM_PRCB, RAM_VRCB, RAM_ORCB: is_good_ram = 1'b1;
            default:                                is_good_ram = 1'b0;
        endcase
    endfunction

    function automatic host_msg_t pack_host_msg(
        input logic [7:0]           cmd,
        input logic [7:0]           ram,
        input logic [15:0]          addr,
        input logic [7:0]           res,
        input logic [BYTE_EN_W-1:0] byte_en,
        input logic [DATA_W-1:0]    data
    );
        logic [MSG_W-1:0] m;
        m = {MSG_W{1'b0}};
        m[CMD_LSB     +: 8]         = cmd;
        m[RAM_LSB     +: 8]         = ram;
        m[ADDR_LSB    +: 16]        = addr;
        m[RES_LSB     +: 8]         = res;
        m[BYTE_EN_LSB +: BYTE_EN_W] = byte_en;
        m[DATA_LSB    +: DATA_W]    = data;
        return host_msg_t'(m);
    endfunction

endpackage

// File: rtl/tts_host_msg_tx.sv
// Host message transmitter: packs a request into a 256-bit message and streams it MSB-first
// as BEAT_W-bit beats. Define TTS_HOST_TX_SEQ_EN to stamp an 8-bit sequence number into res.
module tts_host_msg_tx
    import tts_host_msg_tx_pkg::*;
#(
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_cmd,
    input  logic [7:0]        req_ram,
    input  logic [15:0]       req_addr,
    input  logic [23:0]       req_byte_en,
    input  logic [191:0]      req_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [BEAT_W-1:0] tx_data,
    output logic              tx_sop,
    output logic              tx_eop,
    output logic              busy,
    output logic              err_bad_ram
);

    localparam int         NUM_BEATS = 256 / BEAT_W;
    localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

    tx_state_e    state_r;
    tx_state_e    state_nxt_s;
    logic [1:0]   cnt_r;
    logic [1:0]   cnt_nxt_s;
    logic [255:0] msg_r;
    logic         tx_valid_r;
    logic         tx_sop_r;
    logic         tx_eop_r;
    logic         err_r;
    logic         ready_en_r;
    logic         beat_done_s;
    logic         last_done_s;
    logic         req_ready_s;
    logic         accept_s;
    logic         good_s;
    logic         load_s;
    logic         shift_s;
    logic [7:0]   res_s;

    assign beat_done_s = tx_valid_r && tx_ready;
    assign last_done_s = beat_done_s && (cnt_r == LAST_BEAT);
    // ready_en_r keeps req_ready low through reset and for the first cycle after it.
    assign req_ready_s = ready_en_r && ((state_r == TX_IDLE) || last_done_s);
    assign accept_s    = req_valid && req_ready_s;
    assign good_s      = is_good_ram(req_ram);

    assign req_ready   = req_ready_s;
    assign tx_valid    = tx_valid_r;
    assign tx_data     = msg_r[255 -: BEAT_W];
    assign tx_sop      = tx_sop_r;
    assign tx_eop      = tx_eop_r;
    assign busy        = tx_valid_r;
    assign err_bad_ram = err_r;

`ifdef TTS_HOST_TX_SEQ_EN
    logic [7:0] seq_r;

    // Sequence number advances once per message that will actually be transmitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_r <= 8'd0;
        end else if (load_s) begin
            seq_r <= seq_r + 8'd1;
        end else begin
            seq_r <= seq_r;
        end
    end

    assign res_s = seq_r;
`else
    assign res_s = 8'h00;
`endif

    // Next-state logic: load on good accept, shift one beat per completed non-final beat.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (accept_s && good_s) begin
                    state_nxt_s = TX_SEND;
                    cnt_nxt_s   = 2'd0;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (last_done_s) begin
                    cnt_nxt_s = 2'd0;
                    if (accept_s && good_s) begin
                        state_nxt_s = TX_SEND;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = TX_IDLE;
                    end
                end else if (beat_done_s) begin
                    cnt_nxt_s = cnt_r + 2'd1;
                    shift_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = TX_IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // State, beat register and registered beat flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= TX_IDLE;
            cnt_r      <= 2'd0;
            msg_r      <= {256{1'b0}};
            tx_valid_r <= 1'b0;
            tx_sop_r   <= 1'b0;
            tx_eop_r   <= 1'b0;
            err_r      <= 1'b0;
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            tx_valid_r <= (state_nxt_s == TX_SEND);
            tx_sop_r   <= (state_nxt_s == TX_SEND) && (cnt_nxt_s == 2'd0);
            tx_eop_r   <= (state_nxt_s == TX_SEND) && (cnt_nxt_s == LAST_BEAT);
            err_r      <= accept_s && !good_s;
            ready_en_r <= 1'b1;
            if (load_s) begin
                msg_r <= pack_host_msg(req_cmd, req_ram, req_addr, res_s, req_byte_en, req_data);
            end else if (shift_s) begin
                msg_r <= msg_r << BEAT_W;
            end else begin
                msg_r <= msg_r;
            end
        end
    end

endmodule
